// File: rtl/ps2_mouse_tracker_if.sv
// Byte-stream input and cursor/button outputs of the PS/2 mouse tracker.
interface ps2_mouse_tracker_if #(
    parameter int POS_W = 10
);
    logic [7:0]       rx_data;
    logic             rx_en;
    logic             clear;
    logic [POS_W-1:0] xpos;
    logic [POS_W-1:0] ypos;
    logic [2:0]       btn;
    logic             pkt_valid;
    logic             sync_err;
    logic [7:0]       wheel;

    modport master (
        output rx_data, rx_en, clear,
        input  xpos, ypos, btn, pkt_valid, sync_err, wheel
    );

    modport slave (
        input  rx_data, rx_en, clear,
        output xpos, ypos, btn, pkt_valid, sync_err, wheel
    );
endinterface

// File: rtl/ps2_mouse_tracker.sv
// PS/2 mouse packet framer and clamped cursor accumulator.
// Define MOUSE_WHEEL_EN for 4-byte IntelliMouse packets with a saturating wheel count.
module ps2_mouse_tracker #(
    parameter int POS_W       = 10,
    parameter int X_MAX       = 639,
    parameter int Y_MAX       = 479,
    parameter int X_INIT      = 320,
    parameter int Y_INIT      = 240,
    parameter bit INV_Y       = 1'b1,
    parameter int TIMEOUT_CYC = 1000000
) (
    input  logic                 CLOCK_50,
    input  logic                 resetn,
    ps2_mouse_tracker_if.slave   bus
);
    localparam int SW    = POS_W + 2;
    localparam int CNT_W = $clog2(TIMEOUT_CYC + 1);
    localparam logic signed [SW-1:0] XMAX_S = SW'(X_MAX);
    localparam logic signed [SW-1:0] YMAX_S = SW'(Y_MAX);

    typedef enum logic [2:0] {S_B0, S_B1, S_B2, S_B3, S_UPD} state_t;

    typedef struct packed {
        logic       yovf;
        logic       xovf;
        logic       ysgn;
        logic       xsgn;
        logic [2:0] btn;
    } hdr_t;

    state_t           state_q, state_d;
    hdr_t             hdr_q, hdr_d;
    logic [7:0]       b1_q, b1_d, b2_q, b2_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [POS_W-1:0] xpos_q, xpos_d, ypos_q, ypos_d;
    logic [2:0]       btn_q, btn_d;
    logic [7:0]       wheel_q, wheel_d;
    logic             pkt_valid_q, pkt_valid_d, sync_err_q, sync_err_d;
`ifdef MOUSE_WHEEL_EN
    logic [3:0]       dz_q, dz_d;
    logic signed [8:0] wsum;
`endif

    logic             in_pkt, tmo, hdr_slot;
    logic signed [SW-1:0] dx, dy, xsum, ysum;

    function automatic logic [POS_W-1:0] clamp(input logic signed [SW-1:0] v,
                                               input logic signed [SW-1:0] mx);
        if (v < 0)        return '0;
        else if (v > mx)  return mx[POS_W-1:0];
        else              return v[POS_W-1:0];
    endfunction

    assign in_pkt   = (state_q == S_B1) || (state_q == S_B2) || (state_q == S_B3);
    assign tmo      = in_pkt && !bus.rx_en && (cnt_q == CNT_W'(TIMEOUT_CYC - 1));
    // UPD lasts one cycle, so a byte arriving then is a new header.
    assign hdr_slot = (state_q == S_B0) || (state_q == S_UPD);

    always_ff @(posedge CLOCK_50) begin
        if (!resetn) begin
            state_q     <= S_B0;
            hdr_q       <= '0;
            b1_q        <= '0;
            b2_q        <= '0;
            cnt_q       <= '0;
            xpos_q      <= POS_W'(X_INIT);
            ypos_q      <= POS_W'(Y_INIT);
            btn_q       <= '0;
            wheel_q     <= '0;
            pkt_valid_q <= 1'b0;
            sync_err_q  <= 1'b0;
`ifdef MOUSE_WHEEL_EN
            dz_q        <= '0;
`endif
        end else begin
            state_q     <= state_d;
            hdr_q       <= hdr_d;
            b1_q        <= b1_d;
            b2_q        <= b2_d;
            cnt_q       <= cnt_d;
            xpos_q      <= xpos_d;
            ypos_q      <= ypos_d;
            btn_q       <= btn_d;
            wheel_q     <= wheel_d;
            pkt_valid_q <= pkt_valid_d;
            sync_err_q  <= sync_err_d;
`ifdef MOUSE_WHEEL_EN
            dz_q        <= dz_d;
`endif
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_B0, S_UPD: begin
                if (bus.rx_en && bus.rx_data[3]) state_d = S_B1;
                else                             state_d = S_B0;
            end
            S_B1: begin
                if (bus.rx_en)  state_d = S_B2;
                else if (tmo)   state_d = S_B0;
            end
            S_B2: begin
`ifdef MOUSE_WHEEL_EN
                if (bus.rx_en)  state_d = S_B3;
`else
                if (bus.rx_en)  state_d = S_UPD;
`endif
                else if (tmo)   state_d = S_B0;
            end
            S_B3: begin
                if (bus.rx_en)  state_d = S_UPD;
                else if (tmo)   state_d = S_B0;
            end
            default: state_d = S_B0;
        endcase
    end

    always_comb begin
        hdr_d       = hdr_q;
        b1_d        = b1_q;
        b2_d        = b2_q;
        xpos_d      = xpos_q;
        ypos_d      = ypos_q;
        btn_d       = btn_q;
        wheel_d     = wheel_q;
        pkt_valid_d = 1'b0;
        sync_err_d  = 1'b0;
`ifdef MOUSE_WHEEL_EN
        dz_d        = dz_q;
        wsum        = $signed({wheel_q[7], wheel_q}) + $signed({{5{dz_q[3]}}, dz_q});
`endif

        if (bus.rx_en)          cnt_d = '0;
        else if (in_pkt && !tmo) cnt_d = cnt_q + 1'b1;
        else                    cnt_d = '0;

        if (hdr_slot && bus.rx_en) begin
            if (bus.rx_data[3])
                hdr_d = '{yovf: bus.rx_data[7], xovf: bus.rx_data[6], ysgn: bus.rx_data[5],
                          xsgn: bus.rx_data[4], btn: bus.rx_data[2:0]};
            else
                sync_err_d = 1'b1;
        end
        if (tmo) sync_err_d = 1'b1;

        if (state_q == S_B1 && bus.rx_en) b1_d = bus.rx_data;
        if (state_q == S_B2 && bus.rx_en) b2_d = bus.rx_data;
`ifdef MOUSE_WHEEL_EN
        if (state_q == S_B3 && bus.rx_en) dz_d = bus.rx_data[3:0];
`endif

        // 9-bit two's-complement deltas widened to SW so the sum can never wrap.
        dx   = hdr_q.xovf ? '0 : {{(SW-8){hdr_q.xsgn}}, b1_q};
        dy   = hdr_q.yovf ? '0 : {{(SW-8){hdr_q.ysgn}}, b2_q};
        xsum = $signed({2'b00, xpos_q}) + dx;
        ysum = INV_Y ? ($signed({2'b00, ypos_q}) - dy) : ($signed({2'b00, ypos_q}) + dy);

        if (state_q == S_UPD) begin
            pkt_valid_d = 1'b1;
            btn_d       = hdr_q.btn;
            xpos_d      = clamp(xsum, XMAX_S);
            ypos_d      = clamp(ysum, YMAX_S);
`ifdef MOUSE_WHEEL_EN
            if (wsum > 9'sd127)        wheel_d = 8'h7F;
            else if (wsum < -9'sd128)  wheel_d = 8'h80;
            else                       wheel_d = wsum[7:0];
`endif
        end

        if (bus.clear) begin
            xpos_d  = POS_W'(X_INIT);
            ypos_d  = POS_W'(Y_INIT);
            wheel_d = '0;
        end
`ifndef MOUSE_WHEEL_EN
        wheel_d = '0;
`endif
    end

    assign bus.xpos      = xpos_q;
    assign bus.ypos      = ypos_q;
    assign bus.btn       = btn_q;
    assign bus.wheel     = wheel_q;
    assign bus.pkt_valid = pkt_valid_q;
    assign bus.sync_err  = sync_err_q;
endmodule

// File: tb/tb_ps2_mouse_tracker.sv
// Directed-vector bench for ps2_mouse_tracker with a short timeout.
module tb_ps2_mouse_tracker;
    localparam int TMO = 20;

    logic clk = 1'b0;
    logic resetn = 1'b0;
    int   checks = 0;
    int   failures = 0;
    int   cyc = 0;
    int   pv_cnt = 0;
    int   se_cnt = 0;
    int   pv_cyc = 0;
    int   last_edge = 0;

    ps2_mouse_tracker_if #(.POS_W(10)) bus ();

    ps2_mouse_tracker #(
        .POS_W(10), .X_MAX(639), .Y_MAX(479), .X_INIT(320), .Y_INIT(240),
        .INV_Y(1'b1), .TIMEOUT_CYC(TMO)
    ) dut (
        .CLOCK_50(clk),
        .resetn  (resetn),
        .bus     (bus)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        cyc = cyc + 1;
        #1;
        if (bus.pkt_valid) begin
            pv_cnt = pv_cnt + 1;
            pv_cyc = cyc;
        end
        if (bus.sync_err) se_cnt = se_cnt + 1;
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks = checks + 1;
        if (got !== exp) begin
            failures = failures + 1;
            $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
        end
    endtask

    task automatic idle(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic do_reset();
        @(negedge clk);
        resetn = 1'b0;
        bus.rx_en = 1'b0;
        bus.clear = 1'b0;
        idle(2);
        resetn = 1'b1;
        pv_cnt = 0;
        se_cnt = 0;
    endtask

    task automatic send_byte(input logic [7:0] b);
        @(negedge clk);
        bus.rx_data = b;
        bus.rx_en   = 1'b1;
        last_edge   = cyc + 1;
        @(negedge clk);
        bus.rx_en   = 1'b0;
    endtask

    task automatic send_pkt(input logic [7:0] h, input logic [7:0] a, input logic [7:0] b);
        send_byte(h);
        send_byte(a);
        send_byte(b);
`ifdef MOUSE_WHEEL_EN
        send_byte(8'h00);
`endif
        idle(3);
    endtask

    initial begin
        bus.rx_data = 8'h00;
        bus.rx_en   = 1'b0;
        bus.clear   = 1'b0;

        do_reset();
        idle(1);
        chk("rst_x", 32'(bus.xpos), 32'd320);
        chk("rst_y", 32'(bus.ypos), 32'd240);
        chk("rst_btn", 32'(bus.btn), 32'd0);
        chk("rst_wheel", 32'(bus.wheel), 32'd0);
        chk("rst_pv", 32'(bus.pkt_valid), 32'd0);
        chk("rst_se", 32'(bus.sync_err), 32'd0);

        // basic move and latency
        send_pkt(8'h08, 8'h10, 8'h05);
        chk("t1_x", 32'(bus.xpos), 32'd336);
        chk("t1_y", 32'(bus.ypos), 32'd235);
        chk("t1_pv_cnt", 32'(pv_cnt), 32'd1);
        chk("t1_latency", 32'(pv_cyc - last_edge), 32'd1);

        // left button, negative dx, clamp at 0
        do_reset();
        send_pkt(8'h19, 8'hF0, 8'h00);
        chk("t2_x", 32'(bus.xpos), 32'd304);
        chk("t2_btn", 32'(bus.btn), 32'd1);
        for (int i = 0; i < 20; i++) send_pkt(8'h19, 8'hF0, 8'h00);
        chk("t2_clamp0", 32'(bus.xpos), 32'd0);
        chk("t2_pv_cnt", 32'(pv_cnt), 32'd21);
        chk("t2_se_cnt", 32'(se_cnt), 32'd0);

        // bad sync byte then recovery
        do_reset();
        send_byte(8'h00);
        idle(2);
        chk("t3_se_cnt", 32'(se_cnt), 32'd1);
        send_pkt(8'h08, 8'h01, 8'h01);
        chk("t3_x", 32'(bus.xpos), 32'd321);
        chk("t3_y", 32'(bus.ypos), 32'd239);
        chk("t3_pv_cnt", 32'(pv_cnt), 32'd1);

        // inter-byte timeout
        do_reset();
        send_byte(8'h08);
        send_byte(8'h05);
        idle(TMO + 5);
        chk("t4_se_cnt", 32'(se_cnt), 32'd1);
        chk("t4_pv_none", 32'(pv_cnt), 32'd0);
        send_pkt(8'h08, 8'h00, 8'h00);
        chk("t4_pv_cnt", 32'(pv_cnt), 32'd1);
        chk("t4_x", 32'(bus.xpos), 32'd320);
        chk("t4_y", 32'(bus.ypos), 32'd240);
        // slow but within budget must not time out
        send_byte(8'h08);
        idle(TMO - 6);
        send_byte(8'h10);
        send_byte(8'h05);
        idle(3);
        chk("t4_slow_se", 32'(se_cnt), 32'd1);
        chk("t4_slow_x", 32'(bus.xpos), 32'd336);

        // overflow bits and mid-packet reset
        do_reset();
        send_pkt(8'h48, 8'hFF, 8'h02);
        chk("t5_xovf_x", 32'(bus.xpos), 32'd320);
        chk("t5_xovf_y", 32'(bus.ypos), 32'd238);
        send_pkt(8'h89, 8'h10, 8'h05);
        chk("t5_yovf_x", 32'(bus.xpos), 32'd336);
        chk("t5_yovf_y", 32'(bus.ypos), 32'd238);
        chk("t5_yovf_btn", 32'(bus.btn), 32'd1);
        send_byte(8'h08);
        send_byte(8'h10);
        do_reset();
        idle(1);
        chk("t5_rst_x", 32'(bus.xpos), 32'd320);
        chk("t5_rst_y", 32'(bus.ypos), 32'd240);
        chk("t5_rst_btn", 32'(bus.btn), 32'd0);
        send_pkt(8'h08, 8'h10, 8'h05);
        chk("t5_after_x", 32'(bus.xpos), 32'd336);
        chk("t5_after_pv", 32'(pv_cnt), 32'd1);

        // upper clamps
        do_reset();
        send_pkt(8'h28, 8'h00, 8'h00);
        chk("ymax_clamp", 32'(bus.ypos), 32'd479);
        send_pkt(8'h08, 8'hFF, 8'h00);
        chk("x_575", 32'(bus.xpos), 32'd575);
        send_pkt(8'h08, 8'hFF, 8'h00);
        chk("xmax_clamp", 32'(bus.xpos), 32'd639);

        // clear alone and coincident with update
        do_reset();
        send_pkt(8'h08, 8'h10, 8'h05);
        @(negedge clk); bus.clear = 1'b1;
        @(negedge clk); bus.clear = 1'b0;
        idle(1);
        chk("clr_x", 32'(bus.xpos), 32'd320);
        chk("clr_y", 32'(bus.ypos), 32'd240);
        chk("clr_pv", 32'(pv_cnt), 32'd1);
        bus.clear = 1'b1;
        send_pkt(8'h09, 8'h10, 8'h05);
        bus.clear = 1'b0;
        chk("clr_upd_x", 32'(bus.xpos), 32'd320);
        chk("clr_upd_y", 32'(bus.ypos), 32'd240);
        chk("clr_upd_btn", 32'(bus.btn), 32'd1);
        chk("clr_upd_pv", 32'(pv_cnt), 32'd2);

        // wheel
        do_reset();
`ifdef MOUSE_WHEEL_EN
        send_byte(8'h08); send_byte(8'h00); send_byte(8'h00); send_byte(8'h0F);
        idle(3);
        chk("wheel_m1", 32'(bus.wheel), 32'hFF);
        send_byte(8'h08); send_byte(8'h00); send_byte(8'h00); send_byte(8'h01);
        idle(3);
        chk("wheel_0", 32'(bus.wheel), 32'h00);
`else
        send_pkt(8'h08, 8'h0F, 8'h01);
        chk("wheel_off", 32'(bus.wheel), 32'h00);
        chk("wheel_off_pv", 32'(pv_cnt), 32'd1);
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
